// File: rtl/softmax_pkg.sv
// Shared constants, row tag type and group-length helper for the acc_max
// transmit path.
package softmax_pkg;

  localparam int LANES     = 64;
  localparam int DW        = 16;
  localparam int MODE_W    = 4;
  localparam int PIPE      = 3;
  localparam int ROW_IDX_W = 4;

  localparam logic [MODE_W-1:0] MODE_BYPASS_MAX = MODE_W'(2);
  localparam logic [MODE_W-1:0] MODE_MAX        = MODE_W'(13);

  typedef struct packed {
    logic [MODE_W-1:0]    mode;
    logic [ROW_IDX_W-1:0] row_idx;
    logic                 last;
  } row_tag_t;

  typedef enum logic {
    GRP_IDLE = 1'b0,
    GRP_IN   = 1'b1
  } grp_state_t;

  // Rows in a group for a given length mode; illegal modes behave as bypass.
  function automatic logic [ROW_IDX_W-1:0] rows_for_mode(input logic [MODE_W-1:0] m);
    if (m <= MODE_BYPASS_MAX || m > MODE_MAX) return ROW_IDX_W'(1);
    else return ROW_IDX_W'(m) - ROW_IDX_W'(1);
  endfunction

endpackage

// File: rtl/row_max_issuer_tree.sv
// Three-stage registered signed 4:1 max tree. A side-band payload and a
// valid bit travel through the same stages so they stay row-aligned.
module max_tree64_pipe
  import softmax_pkg::*;
#(
  parameter int LANES = softmax_pkg::LANES,
  parameter int DW    = softmax_pkg::DW,
  parameter int PAY_W = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic [LANES*DW-1:0]  i_data,
  input  logic [PAY_W-1:0]     i_payload,
  output logic                 o_valid,
  output logic signed [DW-1:0] o_max,
  output logic [PAY_W-1:0]     o_payload
);

  localparam int L1 = LANES / 4;
  localparam int L2 = L1 / 4;

  logic signed [DW-1:0] lane   [LANES];
  logic signed [DW-1:0] max_p1 [L1];
  logic signed [DW-1:0] max_p2 [L2];
  logic [PAY_W-1:0]     pay_p1;
  logic [PAY_W-1:0]     pay_p2;
  logic                 vld_p1;
  logic                 vld_p2;

  // Strict greater-than keeps the lower-index operand on ties.
  function automatic logic signed [DW-1:0] max4(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b,
                                                input logic signed [DW-1:0] c,
                                                input logic signed [DW-1:0] d);
    logic signed [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Unpack the flat row into signed lanes.
  always_comb begin
    for (int k = 0; k < LANES; k++) lane[k] = i_data[k*DW +: DW];
  end

  // Valid chain: cleared on reset so in-flight rows are discarded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      o_valid <= 1'b0;
    end else if (i_en) begin
      vld_p1  <= i_valid;
      vld_p2  <= vld_p1;
      o_valid <= vld_p2;
    end
  end

  // Stage 1: 64 lanes -> 16 partial maxima.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int i = 0; i < L1; i++)
        max_p1[i] <= max4(lane[4*i], lane[4*i+1], lane[4*i+2], lane[4*i+3]);
      pay_p1 <= i_payload;
    end
  end

  // Stage 2: 16 -> 4 partial maxima.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int i = 0; i < L2; i++)
        max_p2[i] <= max4(max_p1[4*i], max_p1[4*i+1], max_p1[4*i+2], max_p1[4*i+3]);
      pay_p2 <= pay_p1;
    end
  end

  // Stage 3: final max; these are the block outputs and read zero after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_max     <= '0;
      o_payload <= '0;
    end else if (i_en) begin
      o_max     <= max4(max_p2[0], max_p2[1], max_p2[2], max_p2[3]);
      o_payload <= pay_p2;
    end
  end

endmodule

// File: rtl/row_max_issuer.sv
// acc_max transmit front end: accepts rows, tags them with group mode,
// row index and last flag, and issues them with their lane max at fixed latency.
module row_max_issuer
  import softmax_pkg::*;
#(
  parameter int LANES  = softmax_pkg::LANES,
  parameter int DW     = softmax_pkg::DW,
  parameter int MODE_W = softmax_pkg::MODE_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [MODE_W-1:0]    i_length_mode,
  input  logic [LANES*DW-1:0]  i_row_flat,
  output logic                 o_valid_max,
  output logic signed [DW-1:0] o_max64_0,
  output logic [MODE_W-1:0]    o_length_mode,
  output logic [LANES*DW-1:0]  o_in_flat,
  output logic [3:0]           o_row_idx,
  output logic                 o_last_row,
  output logic                 o_err
);

  localparam int PAY_W = $bits(row_tag_t) + LANES*DW;

  grp_state_t        state_q, state_d;
  logic [MODE_W-1:0] cur_mode_q, cur_mode_d;
  logic [3:0]        row_cnt_q, row_cnt_d;
  logic              err_q, err_d;
  logic              accept;
  row_tag_t          tag;
  row_tag_t          out_tag;
  logic [PAY_W-1:0]  out_payload;

  assign o_ready = i_en & i_rst_n;
  assign accept  = i_valid & o_ready;

  // Group FSM next state and per-row tag; first row of a group uses the live mode.
  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    row_cnt_d  = row_cnt_q;
    err_d      = err_q;
    tag        = '0;
    if (accept) begin
      case (state_q)
        GRP_IDLE: begin
          tag.mode    = i_length_mode;
          tag.row_idx = '0;
          tag.last    = (rows_for_mode(i_length_mode) == 4'd1);
          cur_mode_d  = i_length_mode;
          if (i_length_mode > MODE_MAX) err_d = 1'b1;
          if (tag.last) begin
            row_cnt_d = '0;
          end else begin
            state_d   = GRP_IN;
            row_cnt_d = 4'd1;
          end
        end
        GRP_IN: begin
          tag.mode    = cur_mode_q;
          tag.row_idx = row_cnt_q;
          tag.last    = (row_cnt_q == rows_for_mode(cur_mode_q) - 4'd1);
          if (i_length_mode != cur_mode_q) err_d = 1'b1;
          if (tag.last) begin
            state_d   = GRP_IDLE;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 4'd1;
          end
        end
        default: state_d = GRP_IDLE;
      endcase
    end
  end

  // FSM state, latched mode, row counter and sticky error.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= GRP_IDLE;
      cur_mode_q <= '0;
      row_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else if (i_en) begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      row_cnt_q  <= row_cnt_d;
      err_q      <= err_d;
    end
  end

  max_tree64_pipe #(
    .LANES (LANES),
    .DW    (DW),
    .PAY_W (PAY_W)
  ) u_tree (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (i_en),
    .i_valid   (accept),
    .i_data    (i_row_flat),
    .i_payload ({tag, i_row_flat}),
    .o_valid   (o_valid_max),
    .o_max     (o_max64_0),
    .o_payload (out_payload)
  );

  assign {out_tag, o_in_flat} = out_payload;
  assign o_length_mode        = out_tag.mode;
  assign o_row_idx            = out_tag.row_idx;
  assign o_last_row           = out_tag.last;
  assign o_err                = err_q;

endmodule

// File: doc/row_max_issuer.md
Name: row_max_issuer

Overview:
- Transmit-side front end for acc_max. Accepts full 64-lane rows (64 x 16-bit signed) from the upstream score buffer and computes each row's lane maximum in a pipelined tree.
- Tags each row with its group length mode, group row index and last-row flag, and drives the acc_max input interface (valid, max, length mode, flat data) at fixed latency.
- acc_max has no backpressure, so this block never stalls its output. It only throttles its input through i_en.

Parameters:
- LANES, 64, lanes per row (power of 4 required).
- DW, 16, lane width in bits (signed two's complement).
- MODE_W, 4, width of the length-mode field.
- PIPE, 3, max-tree pipeline depth: log4(LANES), with one register per 4:1 stage.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_en  in  1  global enable, shared with acc_max. When low, every register holds, including the output valid.
- i_valid  in  1  upstream row valid.
- o_ready  out  1  upstream ready. Combinational: o_ready = i_en & i_rst_n.
- i_length_mode  in  MODE_W  group length mode. Sampled only on the first row of a group.
- i_row_flat  in  LANES*DW  row data. Lane k is at bits [16k+15:16k].
- o_valid_max  out  1  row valid toward acc_max.
- o_max64_0  out  DW  signed max of the row's 64 lanes.
- o_length_mode  out  MODE_W  mode latched for the row's group.
- o_in_flat  out  LANES*DW  row data, delayed to align with o_max64_0.
- o_row_idx  out  4  index of the row within its group, 0-based.
- o_last_row  out  1  the row is the last one of its group.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset: i_rst_n low at a rising edge clears all outputs and pipeline valids to 0, the row counter to 0 and o_err to 0. Reset mid-group discards every in-flight row, and the next accepted row starts a new group.
- Accept condition: i_valid & o_ready.
- Rows per group, R(m):
  - m in 0..2 is bypass, R = 1.
  - m in 3..13 gives R = m - 1, covering 2..12 rows.
  - m in 14..15 is illegal. Treat it as bypass (R = 1, forward m unchanged) and set o_err.
- Group FSM:
  - States: IDLE (expecting the first row) and IN_GRP.
  - IDLE, accept: latch cur_mode = i_length_mode, set row_cnt = 0. If R = 1, stay in IDLE; otherwise go to IN_GRP with row_cnt = 1.
  - IN_GRP, accept: tag the row with cur_mode and row_cnt. If row_cnt = R - 1, go to IDLE (last row); otherwise increment row_cnt.
  - IN_GRP, accepted row with i_length_mode != cur_mode: set o_err, still use cur_mode, and continue the group normally.
- Tagging:
  - Each accepted row carries {cur_mode, row_idx, last} into the pipeline alongside its data.
  - On the first row, use i_length_mode directly (same-cycle latch).
- Max tree:
  - Stage 1 reduces 64 lanes to 16, stage 2 reduces 16 to 4, stage 3 reduces 4 to 1. Each stage uses signed 4:1 compares and is registered.
  - Ties: the lower lane index wins. The value is identical either way, so this only matters for determinism.
  - No width growth; the output is exactly DW bits.
- Latency:
  - An accepted row appears on o_valid_max exactly PIPE = 3 enabled cycles later.
  - Throughput is 1 row per enabled cycle. Back-to-back groups need no gap.
  - o_valid_max is high for exactly one enabled cycle per accepted row.
- Enable: i_en low freezes the pipeline and FSM. o_valid_max holds its value, which acc_max ignores because it sees the same i_en.
- Simultaneous events:
  - Reset has priority over i_en and accept.
  - The last row of one group and the first row of the next are handled in consecutive cycles without loss.
- o_err clears only on reset.

Decomposition:
- Shared package softmax_pkg holds:
  - LANES, DW and MODE_W constants.
  - MODE_BYPASS_MAX = 2 and MODE_MAX = 13.
  - Function rows_for_mode(m), returning 1..12.
  - Typedef row_tag_t = {mode, row_idx, last}.
- Sub-module max_tree64_pipe: a 3-stage registered signed max tree with enable. It carries a side-band payload (data plus tag) and a valid bit through the same stages.
- This block contains the FSM, tagging and output registers.

Test Plan:
- Reset, then one row of mode 3 with all lanes 500, then one row with lane 7 = 501 and the rest 0. Required: o_max64_0 = 500 then 501, 3 cycles after each accept; o_row_idx = 0 then 1; o_last_row = 0 then 1; o_length_mode = 3.
- Back-to-back mode 13 (12 rows, row i lane 63 = 100+i, others -5), then mode 3 (2 rows, 2000 and 2001). Required: 14 consecutive valids with max 100..111 then 2000, 2001; idx 0..11 then 0..1; last set on 111 and 2001.
- Signed max: a row with all lanes -300 except lane 0 = -2. Required: max = -2. A row with all lanes 0x8000. Required: max = -32768.
- Mixed groups: mode 0, mode 4 (3 rows), mode 1. Required: tags (0,0,last), (4,0), (4,1), (4,2,last), (1,0,last) in order.
- Errors: mode 3 group whose second row presents mode 5. Required: o_err = 1 and the row is tagged mode 3. A mode 15 row is forwarded as a single-row group with o_err = 1.
- Stalls and reset: drop i_en for 4 cycles mid mode-4 group. Required: no valid is lost or duplicated and the latency extends by 4. Assert i_rst_n low after row 1 of a mode-4 group. Required: outputs are 0, the next row is tagged row_idx 0, and o_err = 0.
